// File: rtl/rggen_axi4lite_bridge_pkg.sv
// Shared access/status encodings for the rggen bus and AXI4-Lite response codes.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_READ  = 2'b10,
    RGGEN_WRITE = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY        = 2'b00,
    RGGEN_EXOKAY      = 2'b01,
    RGGEN_SLAVE_ERROR = 2'b10,
    RGGEN_ERROR       = 2'b11
  } rggen_status;

  localparam logic [1:0] RGGEN_AXI_OKAY   = 2'b00;
  localparam logic [1:0] RGGEN_AXI_SLVERR = 2'b10;

endpackage

// File: rtl/rggen_axi4lite_bridge_if.sv
// Downstream rggen bus: one request/response handshake toward the common adapter.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  import rggen_rtl_pkg::*;

  logic                       valid;
  rggen_access                access;
  logic [ADDRESS_WIDTH-1:0]   address;
  logic [BUS_WIDTH-1:0]       write_data;
  logic [BUS_WIDTH/8-1:0]     strobe;
  logic                       ready;
  rggen_status                status;
  logic [BUS_WIDTH-1:0]       read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rggen_axi4lite_slot.sv
// One-entry AXI channel holding slot; ready while empty, emptied by clear.
module rggen_axi4lite_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  output logic             ready,
  input  logic [WIDTH-1:0] payload,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  assign ready = !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (valid && !full) begin
      full <= 1'b1;
      data <= payload;
    end
  end

endmodule

// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite to rggen bus bridge, one outstanding access, alternating arbitration.
// Optional assertions: define RGGEN_AXI4LITE_BRIDGE_SVA_EN.
module rggen_axi4lite_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic [BUS_WIDTH/8-1:0]   wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [BUS_WIDTH-1:0]     rdata,
  output logic [1:0]               rresp,
  rggen_bus_if.master              bus_if
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  localparam int W_WIDTH    = BUS_WIDTH + STRB_WIDTH;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUS_WAIT = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;

  logic [1:0]               state;
  logic                     grant_write;
  logic                     last_write;
  logic [1:0]               resp;
  logic [BUS_WIDTH-1:0]     rdata_q;

  logic                     aw_full;
  logic                     w_full;
  logic                     ar_full;
  logic [ADDRESS_WIDTH-1:0] aw_addr;
  logic [ADDRESS_WIDTH-1:0] ar_addr;
  logic [W_WIDTH-1:0]       w_data;

  logic write_pending;
  logic read_pending;
  logic pick_write;
  logic bus_done;
  logic clear_write;
  logic clear_read;
  logic resp_done;

  rggen_axi4lite_slot #(.WIDTH(ADDRESS_WIDTH)) u_aw_slot (
    .clk     (i_clk),
    .rst     (i_rst),
    .valid   (awvalid),
    .ready   (awready),
    .payload (awaddr),
    .clear   (clear_write),
    .full    (aw_full),
    .data    (aw_addr)
  );

  rggen_axi4lite_slot #(.WIDTH(W_WIDTH)) u_w_slot (
    .clk     (i_clk),
    .rst     (i_rst),
    .valid   (wvalid),
    .ready   (wready),
    .payload ({wstrb, wdata}),
    .clear   (clear_write),
    .full    (w_full),
    .data    (w_data)
  );

  rggen_axi4lite_slot #(.WIDTH(ADDRESS_WIDTH)) u_ar_slot (
    .clk     (i_clk),
    .rst     (i_rst),
    .valid   (arvalid),
    .ready   (arready),
    .payload (araddr),
    .clear   (clear_read),
    .full    (ar_full),
    .data    (ar_addr)
  );

  assign write_pending = aw_full && w_full;
  assign read_pending  = ar_full;
  // On a tie, the side not granted last time wins.
  assign pick_write    = write_pending && (!read_pending || !last_write);
  assign bus_done      = (state == BUS_WAIT) && bus_if.ready;
  assign clear_write   = bus_done && grant_write;
  assign clear_read    = bus_done && !grant_write;
  assign resp_done     = grant_write ? bready : rready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      grant_write <= 1'b0;
      last_write  <= 1'b0;
      resp        <= 2'b00;
      rdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_pending || read_pending) begin
            state       <= BUS_WAIT;
            grant_write <= pick_write;
            last_write  <= pick_write;
          end
        end
        BUS_WAIT: begin
          if (bus_if.ready) begin
            state   <= RESP;
            resp    <= bus_if.status;
            rdata_q <= bus_if.read_data;
          end
        end
        RESP: begin
          if (resp_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_if.valid      = (state == BUS_WAIT);
  assign bus_if.access     = grant_write ? RGGEN_WRITE : RGGEN_READ;
  assign bus_if.address    = grant_write ? aw_addr : ar_addr;
  assign bus_if.write_data = grant_write ? w_data[BUS_WIDTH-1:0] : '0;
  assign bus_if.strobe     = grant_write ? w_data[W_WIDTH-1:BUS_WIDTH] : '1;

  assign bvalid = (state == RESP) && grant_write;
  assign rvalid = (state == RESP) && !grant_write;
  assign bresp  = resp;
  assign rresp  = resp;
  assign rdata  = rdata_q;

`ifdef RGGEN_AXI4LITE_BRIDGE_SVA_EN
  a_aw_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    awvalid && !awready |=> $stable(awaddr));
  a_w_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    wvalid && !wready |=> $stable(wdata) && $stable(wstrb));
  a_ar_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    arvalid && !arready |=> $stable(araddr));
  a_b_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    bvalid && !bready |=> bvalid && $stable(bresp));
  a_r_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    rvalid && !rready |=> rvalid && $stable(rresp) && $stable(rdata));
  a_bus_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    bus_if.valid && !bus_if.ready |=> bus_if.valid
      && $stable(bus_if.access) && $stable(bus_if.address)
      && $stable(bus_if.write_data) && $stable(bus_if.strobe));
  a_one_resp: assert property (@(posedge i_clk) disable iff (i_rst)
    !(bvalid && rvalid));
`endif

endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Directed self-checking bench for rggen_axi4lite_bridge.
module tb_rggen_axi4lite_bridge;
  import rggen_rtl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [7:0]  awaddr = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [7:0]  araddr = '0;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int errors = 0;
  int checks = 0;

  rggen_bus_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bus_if ();

  rggen_axi4lite_bridge #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .awvalid (awvalid),
    .awready (awready),
    .awaddr  (awaddr),
    .wvalid  (wvalid),
    .wready  (wready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .bvalid  (bvalid),
    .bready  (bready),
    .bresp   (bresp),
    .arvalid (arvalid),
    .arready (arready),
    .araddr  (araddr),
    .rvalid  (rvalid),
    .rready  (rready),
    .rdata   (rdata),
    .rresp   (rresp),
    .bus_if  (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s);
    awvalid = 1'b1; awaddr = a;
    wvalid  = 1'b1; wdata  = d; wstrb = s;
  endtask

  task automatic chk_bus(input string tag, input logic wr,
                         input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    check({tag, "_valid"}, 64'(bus_if.valid), 64'd1);
    check({tag, "_access"}, 64'(bus_if.access),
          wr ? 64'(RGGEN_WRITE) : 64'(RGGEN_READ));
    check({tag, "_addr"}, 64'(bus_if.address), 64'(a));
    check({tag, "_wdata"}, 64'(bus_if.write_data), 64'(d));
    check({tag, "_strb"}, 64'(bus_if.strobe), 64'(s));
  endtask

  initial begin
    bus_if.ready     = 1'b1;
    bus_if.status    = RGGEN_OKAY;
    bus_if.read_data = '0;

    // reset state
    tick(); tick();
    check("rst_bus_valid", 64'(bus_if.valid), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_awready", 64'(awready), 64'd1);
    check("rst_wready", 64'(wready), 64'd1);
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_bresp", 64'(bresp), 64'd0);

    // single write, AW and W together, zero-wait downstream
    drive_write(8'h10, 32'hA5A5_A5A5, 4'hF);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("w1_awready", 64'(awready), 64'd0);
    check("w1_idle_valid", 64'(bus_if.valid), 64'd0);
    tick();
    chk_bus("w1", 1'b1, 8'h10, 32'hA5A5_A5A5, 4'hF);
    tick();
    check("w1_bvalid", 64'(bvalid), 64'd1);
    check("w1_bresp", 64'(bresp), 64'd0);
    check("w1_bus_off", 64'(bus_if.valid), 64'd0);
    check("w1_awready_freed", 64'(awready), 64'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("w1_bdone", 64'(bvalid), 64'd0);

    // W two cycles ahead of AW
    wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'h3;
    tick();
    wvalid = 1'b0;
    check("w2_wready", 64'(wready), 64'd0);
    check("w2_wait0", 64'(bus_if.valid), 64'd0);
    tick();
    check("w2_wait1", 64'(bus_if.valid), 64'd0);
    awvalid = 1'b1; awaddr = 8'h20;
    tick();
    awvalid = 1'b0;
    check("w2_wait2", 64'(bus_if.valid), 64'd0);
    tick();
    chk_bus("w2", 1'b1, 8'h20, 32'h1234_5678, 4'h3);
    tick();
    check("w2_bvalid", 64'(bvalid), 64'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // arbitration: two ties after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus_if.read_data = 32'h0000_BEEF;
    drive_write(8'h30, 32'h1111_1111, 4'hF);
    arvalid = 1'b1; araddr = 8'h08;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    chk_bus("arb1", 1'b1, 8'h30, 32'h1111_1111, 4'hF);
    tick();
    check("arb1_bvalid", 64'(bvalid), 64'd1);
    check("arb1_rvalid", 64'(rvalid), 64'd0);
    drive_write(8'h40, 32'h2222_2222, 4'hC);
    bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    check("arb_idle", 64'(bus_if.valid), 64'd0);
    tick();
    chk_bus("arb2", 1'b0, 8'h08, 32'h0, 4'hF);
    tick();
    check("arb2_rvalid", 64'(rvalid), 64'd1);
    check("arb2_rdata", 64'(rdata), 64'h0000_BEEF);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    tick();
    chk_bus("arb3", 1'b1, 8'h40, 32'h2222_2222, 4'hC);
    tick();
    check("arb3_bvalid", 64'(bvalid), 64'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // SLVERR read with stalled rready
    bus_if.status    = RGGEN_SLAVE_ERROR;
    bus_if.read_data = 32'h0000_DEAD;
    arvalid = 1'b1; araddr = 8'h04;
    tick();
    arvalid = 1'b0;
    tick();
    chk_bus("rd", 1'b0, 8'h04, 32'h0, 4'hF);
    tick();
    bus_if.status    = RGGEN_OKAY;
    bus_if.read_data = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("rd_rvalid_hold", 64'(rvalid), 64'd1);
      check("rd_rresp_hold", 64'(rresp), 64'd2);
      check("rd_rdata_hold", 64'(rdata), 64'h0000_DEAD);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rd_done", 64'(rvalid), 64'd0);

    // reset during BUS_WAIT
    bus_if.ready = 1'b0;
    drive_write(8'h50, 32'h3333_3333, 4'hF);
    arvalid = 1'b1; araddr = 8'h0C;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    check("rw_bus_valid", 64'(bus_if.valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rw_valid_drop", 64'(bus_if.valid), 64'd0);
    check("rw_bvalid", 64'(bvalid), 64'd0);
    #2;
    rst = 1'b0;
    bus_if.ready = 1'b1;
    tick();
    check("rw_awready", 64'(awready), 64'd1);
    check("rw_wready", 64'(wready), 64'd1);
    check("rw_arready", 64'(arready), 64'd1);
    tick();
    check("rw_no_req", 64'(bus_if.valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
